load_store_unit: RTL

//  CPU-side initiator for the byte-addressed data memory. Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, latched request.
package lsu_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } lsu_state_e;

    // Upper address bits live in the memory address register, so only the lane offset is kept here.
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  offset;
        logic [31:0] wdata;
    } lsu_req_t;

    // Access size in bytes; 0 marks an illegal funct3.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, and merges sub-word store data into a word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [NUM_LANES-1:0][7:0] word_b;
    logic [NUM_LANES-1:0][7:0] wr_b;
    logic [NUM_LANES-1:0][7:0] merged_b;
    logic [NUM_LANES-1:0]      be;
    logic [7:0]                sel_b;
    logic [15:0]               sel_h;

    assign word_b = word;
    assign sel_b  = word_b[offset];
    assign sel_h  = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   load_data = {24'd0, sel_b};
            F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   load_data = {16'd0, sel_h};
            default: load_data = word;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LANE = 2'(i);
        assign be[i] = (funct3 == F3_B) ? (offset == LANE) :
                       (funct3 == F3_H) ? (offset[1] == LANE[1]) : 1'b1;
        assign wr_b[i] = (funct3 == F3_W) ? wdata[8*i +: 8] :
                         (funct3 == F3_H) ? wdata[8*(i%2) +: 8] : wdata[7:0];
        assign merged_b[i] = be[i] ? wr_b[i] : word_b[i];
    end

    assign merged = merged_b;

endmodule

// File: rtl/load_store_unit.sv
// Word-aligned data memory initiator for RISC-V byte/half/word loads and stores.
// Sub-word stores are read-modify-write; faulting requests complete without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_req,
    input  logic        I_we,
    input  logic [2:0]  I_funct3,
    input  logic [31:0] I_address,
    input  logic [31:0] I_wdata,
    output logic [31:0] O_rdata,
    output logic        O_done,
    output logic        O_busy,
    output logic        O_fault,
    output logic [31:0] O_mem_address,
    output logic        O_mem_memrw,
    output logic [31:0] O_mem_data,
    input  logic [31:0] I_mem_data
);
    lsu_state_e  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mdata_q, mdata_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic        memrw_q, memrw_d;

    logic [2:0]  acc_size;
    logic        fault_now;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Range check in 33 bits so addresses near 2^32 cannot wrap past the limit.
    assign acc_size  = access_size(I_funct3);
    assign fault_now = (acc_size == 3'd0)
                    || (I_we && (I_funct3 > F3_W))
                    || ((acc_size == 3'd2) && I_address[0])
                    || ((acc_size == 3'd4) && (I_address[1:0] != 2'b00))
                    || (({1'b0, I_address} + {30'd0, acc_size}) > 33'(MEM_BYTES));

    lsu_lane_align u_align (
        .word      (I_mem_data),
        .offset    (req_q.offset),
        .funct3    (req_q.funct3),
        .wdata     (req_q.wdata),
        .load_data (load_ext),
        .merged    (merged)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        fault_d = 1'b0;
        memrw_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_req) begin
                    req_d  = '{we: I_we, funct3: I_funct3, offset: I_address[1:0], wdata: I_wdata};
                    busy_d = 1'b1;
                    if (fault_now) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        maddr_d = {I_address[31:2], 2'b00};
                        if (I_we && (I_funct3 == F3_W)) begin
                            state_d = S_WRITE;
                            mdata_d = I_wdata;
                            memrw_d = 1'b1;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                busy_d = 1'b1;
                if (req_q.we) begin
                    state_d = S_WRITE;
                    mdata_d = merged;
                    memrw_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                    rdata_d = load_ext;
                    done_d  = 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
                busy_d  = 1'b1;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            maddr_q <= '0;
            mdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            memrw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            memrw_q <= memrw_d;
        end
    end

    assign O_rdata       = rdata_q;
    assign O_done        = done_q;
    assign O_busy        = busy_q;
    assign O_fault       = fault_q;
    assign O_mem_address = maddr_q;
    assign O_mem_memrw   = memrw_q;
    assign O_mem_data    = mdata_q;

endmodule
